// File: rtl/prbs_checker.sv
// prbs_checker: serial PRBS receive checker.
// Fills its history from the incoming bits, self-synchronises by predicting each
// next bit from the tap mask, locks after a run of correct predictions, then counts
// mismatches against a free-running local copy of the sequence.
module prbs_checker #(
    parameter int unsigned    N           = 2,
    parameter logic [N-1:0]   TAPS        = 2'b11,
    parameter int unsigned    LOCK_COUNT  = 6,
    parameter int unsigned    UNLOCK_ERRS = 3,
    parameter int unsigned    CW          = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic          din,
    input  logic          clr_err,
    output logic          locked,
    output logic          err_pulse,
    output logic [CW-1:0] err_count
);

    localparam int unsigned FW = $clog2(N + 1);
    localparam int unsigned RW = 8;

    typedef enum logic [1:0] {
        StFill,
        StSearch,
        StLocked
    } state_e;

    state_e        state_q, state_d;
    logic [FW-1:0] fill_q, fill_d;
    logic [N-1:0]  hist_q, hist_d;
    logic [RW-1:0] match_q, match_d;
    logic [RW-1:0] miss_q, miss_d;
    logic          locked_q, locked_d;
    logic          err_pulse_q, err_pulse_d;
    logic [CW-1:0] err_count_q, err_count_d;

    logic pred;
    logic mismatch;
    logic hist_zero;

    // Prediction and next-state for the fill / search / locked sequence.
    always_comb begin
        pred      = ^(hist_q & TAPS);
        mismatch  = (din != pred);
        hist_zero = (hist_q == '0);

        state_d     = state_q;
        fill_d      = fill_q;
        hist_d      = hist_q;
        match_d     = match_q;
        miss_d      = miss_q;
        err_pulse_d = 1'b0;
        err_count_d = err_count_q;

        if (ena) begin
            unique case (state_q)
                StFill: begin
                    hist_d = {hist_q[N-2:0], din};
                    fill_d = fill_q + FW'(1);
                    if (fill_q == FW'(N - 1)) begin
                        state_d = StSearch;
                    end
                end
                StSearch: begin
                    // Self-sync: history always follows the received bits here.
                    hist_d = {hist_q[N-2:0], din};
                    if (mismatch || hist_zero) begin
                        match_d = '0;
                    end else if (match_q == RW'(LOCK_COUNT - 1)) begin
                        state_d = StLocked;
                        match_d = '0;
                        miss_d  = '0;
                    end else begin
                        match_d = match_q + RW'(1);
                    end
                end
                StLocked: begin
                    // Free-running reference so one flipped bit is counted once.
                    hist_d = {hist_q[N-2:0], pred};
                    if (mismatch) begin
                        err_pulse_d = 1'b1;
                        if (err_count_q != '1) begin
                            err_count_d = err_count_q + CW'(1);
                        end
                        if (miss_q == RW'(UNLOCK_ERRS - 1)) begin
                            state_d = StSearch;
                            hist_d  = {hist_q[N-2:0], din};
                            match_d = '0;
                            miss_d  = '0;
                        end else begin
                            miss_d = miss_q + RW'(1);
                        end
                    end else begin
                        miss_d = '0;
                    end
                end
                default: begin
                    state_d = StFill;
                end
            endcase
        end

        // Clear beats a coincident increment; the pulse above is unaffected.
        if (clr_err) begin
            err_count_d = '0;
        end

        locked_d = (state_d == StLocked);
    end

    // State and registered outputs, synchronous reset has priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StFill;
            fill_q      <= '0;
            hist_q      <= '0;
            match_q     <= '0;
            miss_q      <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            hist_q      <= hist_d;
            match_q     <= match_d;
            miss_q      <= miss_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;

endmodule

// File: doc/prbs_checker.md
Name: prbs_checker

Overview:
- Serial receive-side checker for the LFSR/PRBS bit stream produced by the team's seeded shift-register generator.
- Self-synchronises by loading its history from incoming bits and predicts each next bit from the tap polynomial.
- Declares lock after a run of consecutive correct predictions, then counts bit errors against a free-running local copy of the sequence.
- Sits at the far end of the serial link or loopback, feeding lock/error status to the test controller.

Parameters:
- N, 2, LFSR length in bits; history register width.
- TAPS, 2'b11, N-bit feedback mask. Predicted bit = XOR of (hist & TAPS). hist[0] = most recent bit. Default gives x[n] = x[n-1] ^ x[n-2].
- LOCK_COUNT, 6, consecutive matches in SEARCH required to assert locked (range 1..255).
- UNLOCK_ERRS, 3, consecutive mismatches in LOCKED that force return to SEARCH (range 1..255).
- CW, 16, err_count width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- ena  input  1  din is a valid stream bit this cycle; no state changes when low.
- din  input  1  received serial bit.
- clr_err  input  1  synchronous clear of err_count.
- locked  output  1  checker synchronised to the stream.
- err_pulse  output  1  one-cycle pulse for each mismatch detected while LOCKED.
- err_count  output  CW  saturating count of mismatches while LOCKED.

Behaviour:
- Reset (rst=1 at a clk edge): state=FILL, fill counter=0, hist=0, match/miss run counters=0.
  - Outputs after reset: locked=0, err_pulse=0, err_count=0.
  - rst has priority over ena and clr_err.
  - Reset mid-stream discards all sync; fill restarts.
- Only cycles with ena=1 are samples. With ena=0, all state holds and err_pulse=0.
- pred = ^(hist & TAPS), computed combinationally from the current hist.
- FILL:
  - Each sample: hist <= {hist[N-2:0], din}; fill counter increments.
  - After the N-th sample, go to SEARCH. No comparisons are made in FILL.
- SEARCH:
  - Each sample: compare din with pred, then hist <= {hist[N-2:0], din} (self-sync from the received bit).
  - Match with hist != 0: match run +1.
  - Mismatch, or hist == 0 (degenerate all-zero state): match run <= 0.
  - When the match run reaches LOCK_COUNT: go to LOCKED; locked=1 from the next cycle.
  - err_count and err_pulse are unaffected in SEARCH.
- LOCKED:
  - Each sample: hist <= {hist[N-2:0], pred} (free-running reference, so an isolated bit error counts exactly once).
  - Mismatch:
    - err_pulse=1 on the cycle after the sample (registered).
    - err_count +1, saturating at all-ones.
    - miss run +1.
  - Match: miss run <= 0.
  - When the miss run reaches UNLOCK_ERRS: go to SEARCH, locked=0 next cycle, hist reloaded from din on that sample, match run=0.
  - The mismatch that triggers unlock is still counted and pulsed.
- clr_err:
  - err_count <= 0.
  - Coincident with a mismatch, the clear wins: result is 0, but err_pulse still fires.
- Latency:
  - err_pulse and err_count update one clk after the offending sample edge.
  - locked rises one clk after the LOCK_COUNT-th matching sample.
- All counters saturate; no wrap-around.

Test Plan:
- Lock: rst 2 cycles, then ena=1 with stream 1,1,0,1,1,0,... (defaults) -> locked=0 through fill (2 bits) + 5 matches; locked=1 after the 6th match (sample 8); err_count stays 0 over 100 bits.
- Single error: after lock, flip one bit (send 0 instead of 1) -> exactly one err_pulse, err_count=1, locked stays 1, later bits match with no further pulses.
- Unlock: after lock, invert 3 consecutive bits -> err_count=3, locked=0 one cycle after the 3rd bad sample; resume the valid stream -> relock after 6 matches.
- All-zero input: ena=1, din=0 for 50 cycles -> locked never asserts, err_count=0.
- Gaps and clear:
  - Lock, then toggle ena randomly -> no spurious errors.
  - Assert clr_err with err_count=5 -> count 0 next cycle.
  - clr_err coincident with a mismatch -> count 0, pulse 1.
- Reset mid-lock: rst=1 one cycle while locked with err_count=7 -> locked=0, err_count=0 next cycle; lock reacquired after 8 samples.
